// File: rtl/alu_shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer: up to STEP bits per clock; latency 1 + ceil(sh/STEP) from accept.
// One op in flight: req_ready only in IDLE; result holds in DONE until rsp_ready.
module alu_shift_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = 5,
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rd,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // One extra bit so STEP == XLEN still fits alongside the count.
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  cnt;
    logic [1:0]      op;

    logic [SHW:0]    cnt_ext;
    logic [SHW:0]    n;
    logic [SHW-1:0]  cnt_nxt;
    logic [XLEN-1:0] acc_nxt;
    logic [SHW-1:0]  sh_amt;
    logic            rs2_unused;

    assign sh_amt     = rs2[SHW-1:0];
    assign rs2_unused = ^rs2[XLEN-1:SHW];
    assign req_ready  = rst_n && (state == IDLE);
    assign busy       = (state != IDLE);

    always_comb begin
        cnt_ext = {1'b0, cnt};
        n       = (cnt_ext < STEP_W) ? cnt_ext : STEP_W;
        cnt_nxt = SHW'(cnt_ext - n);
        case (op)
            OP_SLL:  acc_nxt = acc << n;
            OP_SRL:  acc_nxt = acc >> n;
            OP_SRA:  acc_nxt = $unsigned($signed(acc) >>> n);
            default: acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rd        <= '0;
            acc       <= '0;
            cnt       <= '0;
            op        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc <= rs1;
                        cnt <= sh_amt;
                        op  <= req_op;
                        // Zero shifts and the reserved op skip straight to the result.
                        if ((sh_amt == '0) || (req_op == OP_RSV)) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rd        <= rs1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    if (cnt_nxt == '0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rd        <= acc_nxt;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq: driver queues expected result/latency, monitor checks each response.
module tb_alu_shift_seq;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rd;
    logic        busy;

    // Second instance with STEP=1 for the single-bit latency case.
    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic [1:0]  b_req_op = 2'b00;
    logic [31:0] b_rs1 = '0;
    logic [31:0] b_rs2 = '0;
    logic        b_rsp_valid;
    logic        b_rsp_ready = 1'b1;
    logic [31:0] b_rd;
    logic        b_busy;

    always #5 clk = ~clk;

    alu_shift_seq #(.XLEN(32), .SHW(5), .STEP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .rs1(rs1), .rs2(rs2), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rd(rd), .busy(busy));

    alu_shift_seq #(.XLEN(32), .SHW(5), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op(b_req_op), .rs1(b_rs1), .rs2(b_rs2), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rd(b_rd), .busy(b_busy));

    typedef struct {
        logic [31:0] rd;
        int          lat;
        time         t_acc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Issue one request; push an expectation unless it is going to be aborted.
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit expect_rsp);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now({name, "_ready_timeout"});
        req_valid = 1'b1;
        req_op    = op;
        rs1       = a;
        rs2       = b;
        @(posedge clk);
        if (expect_rsp) begin
            e.rd = exp; e.lat = lat; e.t_acc = $time; e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        // Scramble fields to show they are only sampled at the accept edge.
        req_valid = 1'b0;
        req_op    = ~op;
        rs1       = ~a;
        rs2       = b + 32'd3;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_q.size() != 0) fail_now({name, "_drain"});
    endtask

    // Monitor: a new response is a rising rsp_valid, since DONE always returns through IDLE.
    initial begin
        logic prev_valid;
        exp_t e;
        int   lat;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    e   = exp_q.pop_front();
                    lat = int'(($time - e.t_acc - 5) / 10) + 1;
                    check({e.name, "_rd"}, rd, e.rd);
                    check({e.name, "_latency"}, lat, e.lat);
                end
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        int bcnt;
        int lat;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rd", rd, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_req_ready_low", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        issue("srl_2_1", SRL, 32'd2, 32'd1, 32'd1, 2, 1'b1);
        issue("srl_1_1", SRL, 32'd1, 32'd1, 32'd0, 2, 1'b1);
        issue("srl_ones_1", SRL, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 2, 1'b1);
        issue("sra_ones_1", SRA, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 2, 1'b1);
        issue("sll_1_0", SLL, 32'd1, 32'd0, 32'd1, 1, 1'b1);
        wait_idle("group12");

        issue("sra_msb_31", SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9, 1'b1);
        bcnt = 0;
        while (busy && bcnt < 100) begin
            bcnt++;
            @(negedge clk);
        end
        check("sra_msb_31_busy_cycles", bcnt, 32'd9);

        issue("srl_rs2_33", SRL, 32'h10, 32'd33, 32'h8, 2, 1'b1);
        issue("rsv_op", RSV, 32'hDEAD_BEEF, 32'd7, 32'hDEAD_BEEF, 1, 1'b1);
        issue("sll_1_31", SLL, 32'd1, 32'd31, 32'h8000_0000, 9, 1'b1);
        issue("srl_msb_5", SRL, 32'h8000_0000, 32'd5, 32'h0400_0000, 3, 1'b1);
        issue("sra_neg_8", SRA, 32'hF000_00F0, 32'd8, 32'hFFF0_0000, 3, 1'b1);
        wait_idle("group34");

        // STEP=1 instance: 31 single-bit steps
        @(negedge clk);
        b_req_op = SRA; b_rs1 = 32'h8000_0000; b_rs2 = 32'd31; b_req_valid = 1'b1;
        check("step1_req_ready", {31'd0, b_req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        lat = 1;
        while (!b_rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("step1_latency", lat, 32'd32);
        check("step1_rd", b_rd, 32'hFFFF_FFFF);

        // Backpressure: hold result in DONE with an intruding request present
        rsp_ready = 1'b0;
        issue("hold_sll_5_4", SLL, 32'd5, 32'd4, 32'h50, 2, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; req_op = SRL; rs1 = 32'hFFFF; rs2 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hold_rsp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("hold_rd_%0d", i), rd, 32'h50);
            check($sformatf("hold_req_ready_%0d", i), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
        wait_idle("hold");

        // Reset mid-SHIFT aborts silently
        issue("abort_sll", SLL, 32'd1, 32'd20, 32'd0, 0, 1'b0);
        @(negedge clk);
        check("abort_in_shift_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rd", rd, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("abort_no_response", {31'd0, rsp_valid}, 32'd0);

        issue("sll_3_2", SLL, 32'd3, 32'd2, 32'd12, 2, 1'b1);
        wait_idle("final");
        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
